// File: rtl/id_ex_pipe_reg_pkg.sv
// id_ex_pipe_reg_pkg: control-bundle bit positions and shared constants for the ID/EX boundary
package id_ex_pipe_reg_pkg;
    localparam int CTRL_W            = 10;
    localparam int CTRL_ALU_SRC      = 0;
    localparam int CTRL_MEM_WRITE    = 1;
    localparam int CTRL_MEM_READ     = 2;
    localparam int CTRL_MEM_TO_REG   = 3;
    localparam int CTRL_PC_TO_REG    = 4;
    localparam int CTRL_WRITE_ENABLE = 5;
    localparam int CTRL_IS_BRANCH    = 6;
    localparam int CTRL_IS_JAL       = 7;
    localparam int CTRL_IS_JALR      = 8;
    localparam int CTRL_IS_ECALL     = 9;
    localparam logic [4:0] REG_X17   = 5'd17;
    typedef logic [CTRL_W-1:0] ctrl_t;
endpackage

// File: rtl/id_ex_hazard_detect.sv
// id_ex_hazard_detect: combinational load-use and ecall-x17 hazard detection
module id_ex_hazard_detect
    import id_ex_pipe_reg_pkg::*;
(
    input  logic       reset,
    input  logic       id_valid,
    input  logic       id_is_jal,
    input  logic       id_is_ecall,
    input  logic       id_alu_src,
    input  logic       id_mem_write,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       ex_valid,
    input  logic       ex_mem_read,
    input  logic       ex_write_enable,
    input  logic [4:0] ex_rd,
    input  logic       ex_flush,
    output logic       hazard_stall
);
    logic uses_rs1, uses_rs2, rd_hit, load_use, ecall_x17, lu;
    assign uses_rs1  = !id_is_jal && !id_is_ecall;
    assign uses_rs2  = (!id_alu_src || id_mem_write) && !id_is_ecall;
    assign rd_hit    = (uses_rs1 && ex_rd == id_rs1) || (uses_rs2 && ex_rd == id_rs2) ||
                       (id_is_ecall && ex_rd == REG_X17);
    assign load_use  = ex_mem_read && ex_rd != 5'd0 && rd_hit;
    // ecall reads x17 in ID, so any in-flight write to it must drain first
    assign ecall_x17 = id_is_ecall && ex_write_enable && ex_rd == REG_X17;
    assign lu        = id_valid && ex_valid && (load_use || ecall_x17);
    assign hazard_stall = lu && !ex_flush && !reset;
endmodule

// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: ID/EX pipeline register with hazard bubbles, freeze, flush and bubble counter
module id_ex_pipe_reg
    import id_ex_pipe_reg_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  ctrl_t           id_ctrl,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [31:0]     id_inst,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic            mem_stall,
    input  logic            ex_flush,
    output ctrl_t           ex_ctrl,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [31:0]     ex_inst,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic            hazard_stall,
    output logic [31:0]     bubble_count
);
    logic bubble, load, counted;
    id_ex_hazard_detect u_hazard (
        .reset           (reset),
        .id_valid        (id_valid),
        .id_is_jal       (id_ctrl[CTRL_IS_JAL]),
        .id_is_ecall     (id_ctrl[CTRL_IS_ECALL]),
        .id_alu_src      (id_ctrl[CTRL_ALU_SRC]),
        .id_mem_write    (id_ctrl[CTRL_MEM_WRITE]),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .ex_valid        (ex_valid),
        .ex_mem_read     (ex_ctrl[CTRL_MEM_READ]),
        .ex_write_enable (ex_ctrl[CTRL_WRITE_ENABLE]),
        .ex_rd           (ex_rd),
        .ex_flush        (ex_flush),
        .hazard_stall    (hazard_stall)
    );
    assign bubble  = ex_flush || hazard_stall;
    assign load    = !bubble && id_valid;
    // a flushed slot only counts as a bubble if it displaced a real instruction
    assign counted = ex_flush ? id_valid : hazard_stall;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_ctrl      <= '0;
            ex_valid     <= 1'b0;
            ex_pc        <= '0;
            ex_rs1_data  <= '0;
            ex_rs2_data  <= '0;
            ex_imm       <= '0;
            ex_inst      <= '0;
            ex_rs1       <= '0;
            ex_rs2       <= '0;
            ex_rd        <= '0;
            bubble_count <= '0;
        end else if (!mem_stall) begin
            ex_ctrl      <= load ? id_ctrl : '0;
            ex_valid     <= load;
            ex_pc        <= bubble ? '0 : id_pc;
            ex_rs1_data  <= bubble ? '0 : id_rs1_data;
            ex_rs2_data  <= bubble ? '0 : id_rs2_data;
            ex_imm       <= bubble ? '0 : id_imm;
            ex_inst      <= bubble ? '0 : id_inst;
            ex_rs1       <= bubble ? '0 : id_rs1;
            ex_rs2       <= bubble ? '0 : id_rs2;
            ex_rd        <= bubble ? '0 : id_rd;
            bubble_count <= bubble_count + {31'd0, counted};
        end
    end
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb_id_ex_pipe_reg: randomized scoreboard bench for id_ex_pipe_reg against a slot-level model
module tb_id_ex_pipe_reg;
    typedef struct packed {
        logic [9:0]  ctrl;
        logic        valid;
        logic [31:0] pc, inst, rs1d, rs2d, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] cnt;
    } slot_t;

    logic        clk = 1'b0, reset = 1'b1;
    logic [9:0]  id_ctrl = '0;
    logic        id_valid = 1'b0, mem_stall = 1'b0, ex_flush = 1'b0;
    logic [31:0] id_pc = '0, id_inst = '0, id_rs1_data = '0, id_rs2_data = '0, id_imm = '0;
    logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic [9:0]  ex_ctrl;
    logic        ex_valid, hazard_stall;
    logic [31:0] ex_pc, ex_inst, ex_rs1_data, ex_rs2_data, ex_imm, bubble_count;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;

    int    n_checks = 0, n_fail = 0;
    slot_t q[$];
    slot_t ms = '0;
    logic [4:0] pool [4] = '{5'd0, 5'd1, 5'd5, 5'd17};

    id_ex_pipe_reg #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .id_ctrl(id_ctrl), .id_valid(id_valid), .id_pc(id_pc),
        .id_inst(id_inst), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .mem_stall(mem_stall), .ex_flush(ex_flush),
        .ex_ctrl(ex_ctrl), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
        .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_inst(ex_inst), .ex_rs1(ex_rs1),
        .ex_rs2(ex_rs2), .ex_rd(ex_rd), .hazard_stall(hazard_stall), .bubble_count(bubble_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // one ID->EX edge: drive ID, predict hazard and the resulting EX slot
    task automatic step(input logic [9:0] c, input logic v, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] rd, input logic st, input logic fl);
        logic ecall, lu, exp_hs;
        slot_t n;
        @(negedge clk);
        id_ctrl = c; id_valid = v; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
        mem_stall = st; ex_flush = fl;
        id_pc = $urandom; id_inst = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
        #1;
        ecall = c[9];
        lu = 1'b0;
        if (v && ms.valid) begin
            if (ms.ctrl[2] && ms.rd != 0) begin
                if (!c[7] && !ecall && ms.rd == r1) lu = 1'b1;
                if ((!c[0] || c[1]) && !ecall && ms.rd == r2) lu = 1'b1;
                if (ecall && ms.rd == 17) lu = 1'b1;
            end
            if (ecall && ms.ctrl[5] && ms.rd == 17) lu = 1'b1;
        end
        exp_hs = lu && !fl;
        chk("hazard_stall", 256'(hazard_stall), 256'(exp_hs));
        n = ms;
        if (!st) begin
            if (fl || exp_hs) begin
                n = '0;
                n.cnt = ms.cnt + ((fl && !v) ? 32'd0 : 32'd1);
            end else begin
                n.ctrl = v ? c : 10'd0; n.valid = v;
                n.pc = id_pc; n.inst = id_inst; n.rs1d = id_rs1_data; n.rs2d = id_rs2_data; n.imm = id_imm;
                n.rs1 = r1; n.rs2 = r2; n.rd = rd;
            end
        end
        q.push_back(n);
        ms = n;
    endtask

    task automatic mid_reset();
        @(negedge clk);
        id_valid = 1'b0; mem_stall = 1'b0; ex_flush = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("rst_ex_valid", 256'(ex_valid), 256'(0));
        chk("rst_ex_ctrl", 256'(ex_ctrl), 256'(0));
        chk("rst_bubble_count", 256'(bubble_count), 256'(0));
        chk("rst_hazard_stall", 256'(hazard_stall), 256'(0));
        ms = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin : monitor
        slot_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                a = {ex_ctrl, ex_valid, ex_pc, ex_inst, ex_rs1_data, ex_rs2_data, ex_imm,
                     ex_rs1, ex_rs2, ex_rd, bubble_count};
                chk("ex_slot", 256'(a), 256'(e));
            end
        end
    end

    initial begin : stimulus
        #1;
        chk("reset_valid", 256'(ex_valid), 256'(0));
        chk("reset_ctrl", 256'(ex_ctrl), 256'(0));
        chk("reset_count", 256'(bubble_count), 256'(0));
        @(negedge clk);
        reset = 1'b0;
        step(10'h010, 1, 1, 2, 3, 0, 0);
        step(10'h02D, 1, 1, 0, 5, 0, 0);
        step(10'h020, 1, 5, 1, 6, 0, 0);
        step(10'h020, 1, 5, 1, 6, 0, 0);
        step(10'h021, 1, 0, 0, 17, 0, 0);
        step(10'h200, 1, 0, 0, 0, 0, 0);
        step(10'h200, 1, 0, 0, 0, 0, 0);
        step(10'h02D, 1, 1, 0, 5, 0, 0);
        for (int i = 0; i < 4; i++) step(10'h020, 1, 5, 1, 6, 1, 0);
        step(10'h020, 1, 5, 1, 6, 0, 0);
        step(10'h020, 1, 5, 1, 6, 0, 0);
        step(10'h02D, 1, 1, 0, 5, 0, 0);
        step(10'h020, 1, 5, 1, 6, 0, 1);
        step(10'h010, 1, 1, 2, 3, 0, 0);
        mid_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 59) == 0) mid_reset();
            else step(10'($urandom), $urandom_range(0, 3) != 0, pool[$urandom_range(0, 3)],
                      pool[$urandom_range(0, 3)], pool[$urandom_range(0, 3)],
                      $urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0);
        end
        repeat (3) @(negedge clk);
        chk("queue_drained", 256'(q.size()), 256'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
